// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: TLP fmt/type encodings, receive-parser states and credit helpers
package pcie_tlp_pkg;

  localparam logic [4:0] TYPE_MEM      = 5'b00000;
  localparam logic [4:0] TYPE_MEMLK    = 5'b00001;
  localparam logic [4:0] TYPE_IO       = 5'b00010;
  localparam logic [4:0] TYPE_CFG0     = 5'b00100;
  localparam logic [4:0] TYPE_CFG1     = 5'b00101;
  localparam logic [4:0] TYPE_MSG_MASK = 5'b11000;
  localparam logic [4:0] TYPE_MSG      = 5'b10000;
  localparam logic [4:0] TYPE_CPL      = 5'b01010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR1 = 2'd1,
    ST_BODY = 2'd2
  } rx_state_e;

  // Data credits are 4 DW each; a length field of 0 encodes 1024 DW.
  function automatic logic [8:0] tlp_data_credits(input logic [9:0] len);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return 9'((l + 11'd3) >> 2);
  endfunction

  // MWr (data-carrying memory request) and all Msg/MsgD variants.
  function automatic logic tlp_is_posted(input logic [1:0] fmt, input logic [4:0] typ);
    return ((typ == TYPE_MEM) && fmt[1]) || ((typ & TYPE_MSG_MASK) == TYPE_MSG);
  endfunction

  // MRd, MRdLk, IO and Cfg requests; completions fall through to "no credit".
  function automatic logic tlp_is_np(input logic [1:0] fmt, input logic [4:0] typ);
    return ((typ == TYPE_MEM) && !fmt[1]) || (typ == TYPE_MEMLK) || (typ == TYPE_IO) ||
           (typ == TYPE_CFG0) || (typ == TYPE_CFG1);
  endfunction

endpackage

// File: rtl/pcie_rx_credit_cnt.sv
// pcie_rx_credit_cnt: wrapping statistic counter with clear-over-increment priority
module pcie_rx_credit_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // clear wins over increment; natural wrap at 2^W
  always_comb cnt_d = clr_i ? '0 : (inc_i ? cnt_q + 1'b1 : cnt_q);

  // counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pcie_rx_credit.sv
// pcie_rx_credit: snoops VC0 rx TLPs and returns header/data credits one cycle after each TLP ends
module pcie_rx_credit
  import pcie_tlp_pkg::*;
#(
  parameter int         CNT_W  = 16,
  parameter logic [7:0] PD_SAT = 8'hFF
) (
  input  logic             clk_125,
  input  logic             sys_rst_n,
  input  logic             rx_st,
  input  logic             rx_end,
  input  logic [15:0]      rx_data,
  input  logic             stat_clr,
  output logic             ph_cr,
  output logic             pd_cr,
  output logic [7:0]       pd_num,
  output logic             nph_cr,
  output logic             npd_cr,
  output logic [CNT_W-1:0] p_cnt,
  output logic [CNT_W-1:0] np_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_e   state_q, state_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [4:0]  type_q, type_d;
  logic [9:0]  len_q, len_d;
  logic        ph_q, ph_d, pd_q, pd_d, nph_q, nph_d, npd_q, npd_d;
  logic [7:0]  pd_num_q, pd_num_d;
  logic [8:0]  data_cr;
  logic        cr_ev, err_ev, posted, non_posted;
  logic        unused_rx_bit;

  assign unused_rx_bit = rx_data[15];

  // state register
  always_ff @(posedge clk_125 or negedge sys_rst_n)
    if (!sys_rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;

  // next state: rx_end always closes the parse, rx_st reopens it at HDR1
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = (rx_st && !rx_end) ? ST_HDR1 : ST_IDLE;
      ST_HDR1: state_d = rx_end ? ST_IDLE : (rx_st ? ST_HDR1 : ST_BODY);
      ST_BODY: state_d = rx_end ? ST_IDLE : (rx_st ? ST_HDR1 : ST_BODY);
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs: header capture, error detection and credit scheduling
  always_comb begin
    fmt_d      = rx_st ? rx_data[14:13] : fmt_q;
    type_d     = rx_st ? rx_data[12:8] : type_q;
    len_d      = (state_q == ST_HDR1 && !rx_st) ? rx_data[9:0] : len_q;
    err_ev     = (rx_st && (rx_end || state_q != ST_IDLE)) || (state_q == ST_HDR1 && rx_end);
    cr_ev      = (state_q == ST_BODY) && rx_end && !rx_st;
    posted     = tlp_is_posted(fmt_q, type_q);
    non_posted = tlp_is_np(fmt_q, type_q);
    ph_d       = cr_ev && posted;
    pd_d       = ph_d && fmt_q[1];
    nph_d      = cr_ev && non_posted;
    npd_d      = nph_d && fmt_q[1];
    data_cr    = tlp_data_credits(len_q);
    pd_num_d   = pd_d ? (data_cr[8] ? PD_SAT : data_cr[7:0]) : pd_num_q;
  end

  // captured header fields and registered credit pulses
  always_ff @(posedge clk_125 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      fmt_q    <= '0;
      type_q   <= '0;
      len_q    <= '0;
      ph_q     <= 1'b0;
      pd_q     <= 1'b0;
      nph_q    <= 1'b0;
      npd_q    <= 1'b0;
      pd_num_q <= '0;
    end else begin
      fmt_q    <= fmt_d;
      type_q   <= type_d;
      len_q    <= len_d;
      ph_q     <= ph_d;
      pd_q     <= pd_d;
      nph_q    <= nph_d;
      npd_q    <= npd_d;
      pd_num_q <= pd_num_d;
    end

  assign ph_cr  = ph_q;
  assign pd_cr  = pd_q;
  assign nph_cr = nph_q;
  assign npd_cr = npd_q;
  assign pd_num = pd_num_q;

  pcie_rx_credit_cnt #(.W(CNT_W)) u_p_cnt (
    .clk_i (clk_125),
    .rst_ni(sys_rst_n),
    .inc_i (ph_d),
    .clr_i (stat_clr),
    .cnt_o (p_cnt)
  );

  pcie_rx_credit_cnt #(.W(CNT_W)) u_np_cnt (
    .clk_i (clk_125),
    .rst_ni(sys_rst_n),
    .inc_i (nph_d),
    .clr_i (stat_clr),
    .cnt_o (np_cnt)
  );

  pcie_rx_credit_cnt #(.W(CNT_W)) u_err_cnt (
    .clk_i (clk_125),
    .rst_ni(sys_rst_n),
    .inc_i (err_ev),
    .clr_i (stat_clr),
    .cnt_o (err_cnt)
  );

endmodule

// File: tb/tb_pcie_rx_credit.sv
// tb_pcie_rx_credit: table-driven TLP vectors plus corner sequences, pulses checked via a scoreboard
module tb_pcie_rx_credit;

  logic        clk_125 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_st = 1'b0, rx_end = 1'b0, stat_clr = 1'b0;
  logic [15:0] rx_data = '0;
  logic        ph_cr, pd_cr, nph_cr, npd_cr;
  logic [7:0]  pd_num;
  logic [15:0] p_cnt, np_cnt, err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int p_exp = 0, np_exp = 0, err_exp = 0;
  logic [7:0] last_pd = 8'h00;

  typedef struct {
    int         cyc;
    logic       ph, pd, nph, npd;
    logic [7:0] pd_num;
  } exp_t;

  typedef struct {
    logic [1:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    int         beats;
    logic       ph, pd, nph, npd;
    logic [7:0] pd_num;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  pcie_rx_credit #(.CNT_W(16), .PD_SAT(8'hFF)) dut (
    .clk_125  (clk_125),
    .sys_rst_n(sys_rst_n),
    .rx_st    (rx_st),
    .rx_end   (rx_end),
    .rx_data  (rx_data),
    .stat_clr (stat_clr),
    .ph_cr    (ph_cr),
    .pd_cr    (pd_cr),
    .pd_num   (pd_num),
    .nph_cr   (nph_cr),
    .npd_cr   (npd_cr),
    .p_cnt    (p_cnt),
    .np_cnt   (np_cnt),
    .err_cnt  (err_cnt)
  );

  always #4 clk_125 = ~clk_125;
  always @(posedge clk_125) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Pulses are compared against the scoreboard front when due; otherwise all must be low.
  always @(negedge clk_125) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("ph_cr", int'(ph_cr), int'(e.ph));
      chk("pd_cr", int'(pd_cr), int'(e.pd));
      chk("nph_cr", int'(nph_cr), int'(e.nph));
      chk("npd_cr", int'(npd_cr), int'(e.npd));
      if (e.pd) chk("pd_num", int'(pd_num), int'(e.pd_num));
    end else begin
      chk("no_pulse", int'({ph_cr, pd_cr, nph_cr, npd_cr}), 0);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_expect", e.cyc, cyc);
      end
    end
  end

  task automatic beat(input logic st, input logic en, input logic [15:0] d, input logic clr);
    @(posedge clk_125);
    #1;
    rx_st = st;
    rx_end = en;
    rx_data = d;
    stat_clr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  function automatic logic [15:0] hdr0(input logic [1:0] fmt, input logic [4:0] typ);
    return {1'b0, fmt, typ, 8'h00};
  endfunction

  // Drives a whole TLP back-to-back beats; expectation is queued on the rx_end beat.
  task automatic send(input vec_t v, input logic clr_last);
    beat(1'b1, 1'b0, hdr0(v.fmt, v.typ), 1'b0);
    beat(1'b0, 1'b0, {6'h00, v.len}, 1'b0);
    for (int i = 2; i < v.beats; i++) begin
      beat(1'b0, i == v.beats - 1, 16'($urandom), (i == v.beats - 1) && clr_last);
      if (i == v.beats - 1 && (v.ph || v.nph))
        sb.push_back('{cyc + 1, v.ph, v.pd, v.nph, v.npd, v.pd_num});
    end
    if (v.ph) p_exp++;
    if (v.nph) np_exp++;
    if (v.pd) last_pd = v.pd_num;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_p_cnt"}, int'(p_cnt), p_exp);
    chk({tag, "_np_cnt"}, int'(np_cnt), np_exp);
    chk({tag, "_err_cnt"}, int'(err_cnt), err_exp);
  endtask

  vec_t mwr;

  initial begin
    //            fmt    type      len  beats ph pd nph npd pd_num
    vecs[0]  = '{2'b10, 5'b00000, 10'd10,   8, 1, 1, 0, 0, 8'd3};
    vecs[1]  = '{2'b00, 5'b00000, 10'd1,    6, 0, 0, 1, 0, 8'd0};
    vecs[2]  = '{2'b10, 5'b00000, 10'd0,   10, 1, 1, 0, 0, 8'hFF};
    vecs[3]  = '{2'b10, 5'b00100, 10'd1,    8, 0, 0, 1, 1, 8'd0};
    vecs[4]  = '{2'b00, 5'b01010, 10'd1,    6, 0, 0, 0, 0, 8'd0};
    vecs[5]  = '{2'b11, 5'b10011, 10'd4,   16, 1, 1, 0, 0, 8'd1};
    vecs[6]  = '{2'b10, 5'b00010, 10'd1,    8, 0, 0, 1, 1, 8'd0};
    vecs[7]  = '{2'b00, 5'b00001, 10'd1,    6, 0, 0, 1, 0, 8'd0};
    vecs[8]  = '{2'b11, 5'b00000, 10'd1000, 10, 1, 1, 0, 0, 8'd250};
    vecs[9]  = '{2'b10, 5'b00000, 10'd1021, 10, 1, 1, 0, 0, 8'hFF};
    vecs[10] = '{2'b01, 5'b10100, 10'd0,    8, 1, 0, 0, 0, 8'd0};
    vecs[11] = '{2'b10, 5'b00000, 10'd5,    9, 1, 1, 0, 0, 8'd2};
    mwr      = '{2'b10, 5'b00000, 10'd8,    8, 1, 1, 0, 0, 8'd2};

    repeat (3) @(posedge clk_125);
    @(negedge clk_125);
    chk("rst_pulses", int'({ph_cr, pd_cr, nph_cr, npd_cr}), 0);
    chk("rst_pd_num", int'(pd_num), 0);
    chk_cnts("rst");
    @(posedge clk_125);
    #1 sys_rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i], 1'b0);
      idle(2);
      chk_cnts($sformatf("vec%0d", i));
    end
    chk("pd_num_hold", int'(pd_num), int'(last_pd));

    // rx_end on the second header beat: too short, error only
    beat(1'b1, 1'b0, hdr0(2'b10, 5'b00000), 1'b0);
    beat(1'b0, 1'b1, 16'h0004, 1'b0);
    err_exp++;
    idle(2);
    chk_cnts("short_hdr1");

    // single-beat TLP
    beat(1'b1, 1'b1, hdr0(2'b00, 5'b00000), 1'b0);
    err_exp++;
    idle(2);
    chk_cnts("single_beat");

    // back-to-back MWr, second rx_st in the pulse cycle of the first
    send(mwr, 1'b0);
    send(mwr, 1'b0);
    idle(2);
    chk_cnts("b2b");

    // MRd abandoned mid-BODY by a new MWr
    beat(1'b1, 1'b0, hdr0(2'b00, 5'b00000), 1'b0);
    beat(1'b0, 1'b0, 16'h0001, 1'b0);
    beat(1'b0, 1'b0, 16'h1234, 1'b0);
    err_exp++;
    send(mwr, 1'b0);
    idle(2);
    chk_cnts("abort");

    // stat_clr coinciding with a credit: pulse still fires, clear wins
    send(mwr, 1'b1);
    p_exp = 0;
    np_exp = 0;
    err_exp = 0;
    idle(2);
    chk_cnts("clr_prio");

    // build some counts, then reset mid-TLP
    send(vecs[1], 1'b0);
    beat(1'b1, 1'b0, hdr0(2'b10, 5'b00000), 1'b0);
    beat(1'b0, 1'b0, 16'h0010, 1'b0);
    beat(1'b0, 1'b0, 16'h5555, 1'b0);
    @(posedge clk_125);
    #1;
    sys_rst_n = 1'b0;
    rx_st = 1'b0;
    rx_end = 1'b0;
    @(negedge clk_125);
    p_exp = 0;
    np_exp = 0;
    err_exp = 0;
    chk("midrst_pulses", int'({ph_cr, pd_cr, nph_cr, npd_cr}), 0);
    chk("midrst_pd_num", int'(pd_num), 0);
    chk_cnts("midrst");
    @(posedge clk_125);
    #1 sys_rst_n = 1'b1;
    beat(1'b0, 1'b1, 16'h5555, 1'b0);
    idle(3);
    chk_cnts("post_rst");
    send(vecs[0], 1'b0);
    idle(3);
    chk_cnts("fresh_parse");

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_rx_credit.md
Name: pcie_rx_credit

Overview:
- Receive-side credit return stage between the PCIe core's VC0 receive TLP stream and its credit-processed inputs.
- Snoops every received TLP on the 16-bit rx bus and classifies it as posted, non-posted or completion/other.
- Returns posted-header, posted-data, non-posted-header and non-posted-data credits to the core one cycle after the TLP ends.
- Replaces the credit logic inside ethpipe_mid, so buffer handling and credit return are decoupled. Also keeps debug counters.

Parameters:
- CNT_W, 16, width of the posted, non-posted and error statistic counters.
- PD_SAT, 8'hFF, value driven on pd_num when the computed data-credit count exceeds 8 bits.

Ports:
- clk_125  in  1  core user clock; all logic is on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- rx_st  in  1  first beat of a TLP.
- rx_end  in  1  last beat of a TLP.
- rx_data  in  16  TLP beat; big-endian, header DW0 bytes 0-1 on beat 0.
- stat_clr  in  1  synchronous clear of the statistic counters.
- ph_cr  out  1  posted-header credit processed, 1-cycle pulse.
- pd_cr  out  1  posted-data credit processed, 1-cycle pulse.
- pd_num  out  8  posted-data credits returned with pd_cr.
- nph_cr  out  1  non-posted-header credit processed, 1-cycle pulse.
- npd_cr  out  1  non-posted-data credit processed (the core counts it as 1 credit), 1-cycle pulse.
- p_cnt  out  CNT_W  posted TLPs credited.
- np_cnt  out  CNT_W  non-posted TLPs credited.
- err_cnt  out  CNT_W  truncated or aborted TLPs.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE.
- FSM states: IDLE, HDR1, BODY.
- IDLE:
  - On rx_st, capture fmt = rx_data[14:13] and type = rx_data[12:8], then go to HDR1.
  - If rx_st and rx_end are both high, count an error and stay in IDLE.
- HDR1:
  - Capture len = rx_data[9:0], then go to BODY.
  - If rx_end is high here (TLP too short), count an error, return no credit and go to IDLE.
- BODY: on rx_end, go to IDLE and schedule the credit return.
- Classification (from fmt/type):
  - Posted: type 00000 with fmt 1x (MWr); type 10xxx (Msg/MsgD).
  - Non-posted: type 00000 with fmt 0x (MRd); 00001 (MRdLk); 00010 (IO); 0010x (Cfg).
  - Anything else (completions, unknown types): no credit, no count.
- Credit return, in the cycle after the rx_end beat:
  - Posted: ph_cr = 1. If fmt[1] = 1, also pd_cr = 1 with pd_num = ceil(L/4), where L = 1024 when len = 0, else len. Results above 255 drive PD_SAT.
  - Non-posted: nph_cr = 1. If fmt[1] = 1 (IOWr/CfgWr), also npd_cr = 1.
- Pulse timing:
  - Each pulse is high for exactly one cycle.
  - pd_num is registered and holds its value until the next pd_cr; it only has meaning while pd_cr = 1.
- Back-to-back TLPs: rx_st in the same cycle as a credit pulse is legal, and both are handled. There is no stall and no ready signal; the block never back-pressures.
- Abort: rx_st while in HDR1 or BODY means the previous TLP is abandoned. Count an error, return no credit for it, capture the new header, go to HDR1.
- Counters:
  - A counter increments in the same cycle as its credit pulse; counters wrap at 2^CNT_W.
  - stat_clr has priority over increment.
- Reset mid-TLP discards the partial TLP; the next rx_st starts a fresh parse.

Decomposition:
- Package pcie_tlp_pkg holds:
  - Fmt/type encodings: TYPE_MEM, TYPE_MEMLK, TYPE_IO, TYPE_CFG0/1, TYPE_MSG_MASK, TYPE_CPL.
  - FSM state encodings.
  - Function tlp_data_credits(len).
- Sub-module pcie_rx_credit_cnt: a single CNT_W counter with inc/clr inputs, instantiated three times.

Test Plan:
- MWr, 3DW header, len = 10 (8 beats): one cycle after rx_end, ph_cr = pd_cr = 1 with pd_num = 3; nph_cr = 0; p_cnt = 1.
- MRd, len = 1: nph_cr pulses once; npd_cr, pd_cr and ph_cr stay 0; np_cnt = 1.
- MWr with len = 0 and CfgWr: pd_num = PD_SAT (8'hFF); CfgWr gives nph_cr = npd_cr = 1 in the same cycle.
- Completion (type 01010), then a TLP where rx_end arrives at HDR1: no pulses; err_cnt = 1.
- Two MWr back-to-back with the second rx_st in the pulse cycle: two ph_cr pulses 1 cycle after each rx_end; p_cnt = 2.
- rx_st mid-BODY of an MRd, followed by a complete MWr: no nph_cr; one ph_cr; err_cnt = 1. Then sys_rst_n low for 1 cycle mid-TLP: all outputs 0 and no pulse.
